julia_pixel_engine: RTL and testbench

//   Producer side of the bitmap draw interface (draw/x/y/i) into the VGA/SDRAM framebuffer.

---
 rtl/julia_pixel_engine.sv | 155 +++++++++++++++
 tb/tb_julia_pixel_engine.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/julia_pixel_engine.sv
// rtl/julia_pixel_engine.sv - raster-scan Julia set iterator producing one draw beat per pixel
// Each pixel runs z <- z^2 + c in signed fixed point and reports its escape iteration count.
module julia_pixel_engine #(
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int MAX_ITER = 255,
  parameter int W        = 32,
  parameter int FRAC     = 24
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic signed [W-1:0] c_re,
  input  logic signed [W-1:0] c_im,
  input  logic signed [W-1:0] x_min,
  input  logic signed [W-1:0] y_max,
  input  logic signed [W-1:0] step,
  output logic                draw,
  input  logic                ready,
  output logic [15:0]         x,
  output logic [15:0]         y,
  output logic [7:0]          i,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_ITER, S_EMIT, S_DONE} state_t;

  localparam logic [15:0]         X_LAST    = 16'(H_RES - 1);
  localparam logic [15:0]         Y_LAST    = 16'(V_RES - 1);
  localparam logic [7:0]          ITER_LAST = 8'(MAX_ITER);
  localparam logic signed [W:0]   ESC_LIM   = (W+1)'(64'd4 << FRAC);

  state_t state, state_next;

  logic signed [W-1:0]   c_re_q, c_im_q, x_min_q, step_q;
  logic signed [W-1:0]   zr0, zi0, zr, zi;
  logic [7:0]            iter;
  logic signed [2*W-1:0] zr_ext, zi_ext, p_rr, p_ii, p_ri;
  logic signed [W-1:0]   rr, ii, ri;
  logic signed [W:0]     mag;
  logic                  escape, iter_end, x_end, y_end, launch;

  // Full-width signed products, rescaled back to the working format.
  assign zr_ext = {{W{zr[W-1]}}, zr};
  assign zi_ext = {{W{zi[W-1]}}, zi};
  assign p_rr   = zr_ext * zr_ext;
  assign p_ii   = zi_ext * zi_ext;
  assign p_ri   = zr_ext * zi_ext;
  assign rr     = W'(p_rr >>> FRAC);
  assign ii     = W'(p_ii >>> FRAC);
  assign ri     = W'(p_ri >>> FRAC);

  // One guard bit so the magnitude test cannot wrap.
  assign mag      = {rr[W-1], rr} + {ii[W-1], ii};
  assign escape   = mag > ESC_LIM;
  assign iter_end = escape || (iter == ITER_LAST);
  assign x_end    = (x == X_LAST);
  assign y_end    = (y == Y_LAST);
  assign launch   = (state == S_IDLE) && start && !abort;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) state <= S_IDLE;
    else                state <= state_next;
  end

  always_comb begin
    state_next = state;
    draw       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: if (launch) state_next = S_INIT;
      S_INIT: begin
        busy       = 1'b1;
        state_next = S_ITER;
      end
      S_ITER: begin
        busy = 1'b1;
        if (iter_end) state_next = S_EMIT;
      end
      S_EMIT: begin
        busy = 1'b1;
        draw = 1'b1;
        if (ready) state_next = (x_end && y_end) ? S_DONE : S_INIT;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (abort && state != S_IDLE) begin
      state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      c_re_q  <= '0;
      c_im_q  <= '0;
      x_min_q <= '0;
      step_q  <= '0;
      zr0     <= '0;
      zi0     <= '0;
      zr      <= '0;
      zi      <= '0;
      iter    <= '0;
      x       <= '0;
      y       <= '0;
      i       <= '0;
    end else begin
      case (state)
        S_IDLE: if (launch) begin
          c_re_q  <= c_re;
          c_im_q  <= c_im;
          x_min_q <= x_min;
          step_q  <= step;
          zr0     <= x_min;
          zi0     <= y_max;
          x       <= '0;
          y       <= '0;
        end
        S_INIT: begin
          zr   <= zr0;
          zi   <= zi0;
          iter <= '0;
        end
        S_ITER: begin
          if (iter_end) begin
            i <= iter;
          end else begin
            zr   <= rr - ii + c_re_q;
            zi   <= (ri <<< 1) + c_im_q;
            iter <= iter + 8'd1;
          end
        end
        S_EMIT: if (ready && !(x_end && y_end)) begin
          if (x_end) begin
            x   <= '0;
            y   <= y + 16'd1;
            zr0 <= x_min_q;
            zi0 <= zi0 - step_q;
          end else begin
            x   <= x + 16'd1;
            zr0 <= zr0 + step_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_julia_pixel_engine.sv
// tb/tb_julia_pixel_engine.sv - randomized self-checking bench for julia_pixel_engine
module tb_julia_pixel_engine;

  localparam int H    = 4;
  localparam int V    = 2;
  localparam int NPIX = H * V;
  localparam int ONE  = 1 << 24;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, ready;
  logic signed [31:0] c_re, c_im, x_min, y_max, step;
  logic        draw, busy, done;
  logic [15:0] x, y;
  logic [7:0]  i;

  always #5 clk = ~clk;

  julia_pixel_engine #(
    .H_RES(H), .V_RES(V), .MAX_ITER(255), .W(32), .FRAC(24)
  ) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .start(start), .abort(abort),
    .c_re(c_re), .c_im(c_im), .x_min(x_min), .y_max(y_max), .step(step),
    .draw(draw), .ready(ready), .x(x), .y(y), .i(i), .busy(busy), .done(done)
  );

  int vectors    = 0;
  int miscompares = 0;
  int exp_i[NPIX];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int fx_mul(input int a, input int b);
    longint p;
    p = longint'(a) * longint'(b);
    return int'(p >>> 24);
  endfunction

  function automatic int julia_count(input int zr_in, input int zi_in, input int cr, input int ci);
    int zr, zi, rr, ii, ri;
    zr = zr_in;
    zi = zi_in;
    for (int n = 0; n <= 255; n++) begin
      rr = fx_mul(zr, zr);
      ii = fx_mul(zi, zi);
      ri = fx_mul(zr, zi);
      if (longint'(rr) + longint'(ii) > 64'sd67108864 || n == 255) return n;
      zr = rr - ii + cr;
      zi = 2 * ri + ci;
    end
    return 255;
  endfunction

  task automatic fill_model(input int cr, input int ci, input int xm, input int ym, input int st);
    for (int k = 0; k < NPIX; k++)
      exp_i[k] = julia_count(xm + (k % H) * st, ym - (k / H) * st, cr, ci);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_draw"}, 32'(draw), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // ready_mode: 0 always ready, 1 random, 2 stall five cycles per beat
  task automatic run_frame(input int cr, input int ci, input int xm, input int ym, input int st,
                           input int ready_mode, input bit disturb);
    int k = 0;
    int stall = 0;
    bit hold = 0;
    bit finished = 0;
    logic [15:0] hx, hy;
    logic [7:0]  hi;
    @(negedge clk);
    c_re = cr; c_im = ci; x_min = xm; y_max = ym; step = st;
    start = 1'b1;
    ready = 1'b1;
    for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        check_eq("frame_len", 32'(k), 32'(NPIX));
        check_eq("busy_at_done", 32'(busy), 32'd0);
        check_eq("draw_at_done", 32'(draw), 32'd0);
        finished = 1;
        ready = 1'b1;
      end else begin
        check_eq("busy_in_frame", 32'(busy), 32'd1);
        if (hold) begin
          check_eq("hold_draw", 32'(draw), 32'd1);
          check_eq("hold_x", 32'(x), 32'(hx));
          check_eq("hold_y", 32'(y), 32'(hy));
          check_eq("hold_i", 32'(i), 32'(hi));
        end
        case (ready_mode)
          0:       ready = 1'b1;
          1:       ready = 1'($urandom_range(0, 1));
          default: ready = (stall >= 5);
        endcase
        if (draw) begin
          if (ready) begin
            check_eq("beat_x", 32'(x), 32'(k % H));
            check_eq("beat_y", 32'(y), 32'(k / H));
            check_eq("beat_i", 32'(i), 32'(exp_i[k < NPIX ? k : NPIX-1]));
            k++;
            hold = 0;
            stall = 0;
          end else begin
            hold = 1;
            hx = x; hy = y; hi = i;
            stall++;
          end
        end else begin
          hold = 0;
        end
        if (disturb) begin
          start = 1'($urandom_range(0, 1));
          c_re  = $urandom;
          c_im  = $urandom;
          x_min = $urandom;
          y_max = $urandom;
          step  = $urandom;
        end
      end
    end
    if (!finished) check_eq("frame_timeout", 32'd0, 32'd1);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check_eq("post_done", 32'(done), 32'd0);
      check_eq("post_draw", 32'(draw), 32'd0);
    end
  endtask

  initial begin
    int transfers;
    bit seen;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b1;
    c_re = '0; c_im = '0; x_min = '0; y_max = '0; step = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check_eq("reset_x", 32'(x), 32'd0);
    check_eq("reset_y", 32'(y), 32'd0);
    check_eq("reset_i", 32'(i), 32'd0);
    rst_n = 1'b1;

    // Reference frame with known escape counts
    exp_i = '{0, 2, 255, 2, 1, 255, 255, 255};
    run_frame(0, 0, -2 * ONE, ONE, ONE, 0, 0);
    // Back-to-back second frame, five-cycle stalls per beat
    run_frame(0, 0, -2 * ONE, ONE, ONE, 2, 0);

    // Abort during the long iteration of pixel (2,0)
    @(negedge clk);
    c_re = 0; c_im = 0; x_min = -2 * ONE; y_max = ONE; step = ONE;
    start = 1'b1; ready = 1'b1;
    transfers = 0;
    for (int cyc = 0; cyc < 2000 && transfers < 2; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (draw && ready) transfers++;
    end
    check_eq("abort_setup", 32'(transfers), 32'd2);
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle_outputs("abort");
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done || busy || draw) seen = 1;
    end
    check_eq("abort_quiet", 32'(seen), 32'd0);
    run_frame(0, 0, -2 * ONE, ONE, ONE, 1, 0);

    // Reset while a beat is stalled
    @(negedge clk);
    start = 1'b1; ready = 1'b0;
    seen = 0;
    for (int cyc = 0; cyc < 2000 && !seen; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (draw) seen = 1;
    end
    check_eq("reset_setup", 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle_outputs("midreset");
    check_eq("midreset_x", 32'(x), 32'd0);
    check_eq("midreset_y", 32'(y), 32'd0);
    check_eq("midreset_i", 32'(i), 32'd0);

    // Random parameters against the reference model, some with input churn
    for (int f = 0; f < 6; f++) begin
      int cr, ci, xm, ym, st;
      cr = int'($urandom_range(0, 2 * ONE)) - ONE;
      ci = int'($urandom_range(0, 2 * ONE)) - ONE;
      xm = -int'($urandom_range(0, 2 * ONE));
      ym = int'($urandom_range(0, 3 * ONE / 2));
      st = int'($urandom_range(ONE / 8, ONE));
      fill_model(cr, ci, xm, ym, st);
      run_frame(cr, ci, xm, ym, st, 1, f[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
